rom_burst_arbiter: RTL and testbench

- Shares one synchronous-read ROM (10-bit address, 8-bit data, 1-cycle read latency) between two requesters.
- Each requester asks for a burst of consecutive words. The block arbitrates round-robin, sequences the ROM address for the granted burst, and returns the data tagged with the requester id.
- Sits between the ROM and its two consumers. It is the only driver of the ROM address.

---
 rtl/rom_burst_arbiter.sv | 100 ++++++++++
 tb/tb_rom_burst_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM between two burst requesters.
// state | meaning: IDLE wait for req / ISSUE present one address per cycle / DRAIN return final beat
module rom_burst_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_dataout,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   remaining, remaining_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               ptr, ptr_nxt;
  logic               winner, winner_nxt;
  logic               gnt0_nxt, gnt1_nxt;
  logic               win0, win1;

  // ptr=0 favours requester 0 on a two-way contest
  assign win0 = req0 & (~req1 | ~ptr);
  assign win1 = req1 & (~req0 | ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      rom_address <= '0;
      ptr         <= 1'b0;
      winner      <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid      <= 1'b0;
      rid         <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      rom_address <= addr_nxt;
      ptr         <= ptr_nxt;
      winner      <= winner_nxt;
      gnt0        <= gnt0_nxt;
      gnt1        <= gnt1_nxt;
      rvalid      <= (state == ISSUE);
      rid         <= winner;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    addr_nxt      = rom_address;
    ptr_nxt       = ptr;
    winner_nxt    = winner;
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt     = ISSUE;
          gnt0_nxt      = win0;
          gnt1_nxt      = win1;
          winner_nxt    = win1;
          addr_nxt      = win1 ? addr1 : addr0;
          remaining_nxt = win1 ? len1 : len0;
          if (req0 && req1) ptr_nxt = ~ptr;
        end
      end
      ISSUE: begin
        if (remaining == '0) begin
          state_nxt = DRAIN;
        end else begin
          addr_nxt      = rom_address + ADDR_W'(1);
          remaining_nxt = remaining - LEN_W'(1);
        end
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rdata = rom_dataout;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter: expected beats queued at grant, compared on rvalid.
module tb_rom_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [9:0] addr0, addr1;
  logic [3:0] len0, len1;
  logic       gnt0, gnt1;
  logic [9:0] rom_address;
  logic [7:0] rom_dataout;
  logic [7:0] rdata;
  logic       rvalid, rid, busy;

  int         n_checks = 0;
  int         n_pass = 0;
  logic       ptr_m = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  rom_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .len0(len0),
    .req1(req1), .addr1(addr1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rom_address(rom_address), .rom_dataout(rom_dataout),
    .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy)
  );

  always @(posedge clk) rom_dataout <= rom_address[7:0] ^ 8'hA5;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 32'(rvalid), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("beat_rid", 32'(rid), 32'(e[8]));
        check("beat_data", 32'(rdata), 32'(e[7:0]));
      end
    end
  end

  task automatic do_req(input logic r0, input logic [9:0] a0, input logic [3:0] l0,
                        input logic r1, input logic [9:0] a1, input logic [3:0] l1);
    logic       w;
    logic [9:0] a, ai;
    logic [3:0] l;
    int         n;
    @(negedge clk);
    req0 = r0; addr0 = a0; len0 = l0;
    req1 = r1; addr1 = a1; len1 = l1;
    while (req0 || req1) begin
      if (req0 && req1) begin
        w = ptr_m;
        ptr_m = ~ptr_m;
      end else begin
        w = req1;
      end
      n = 0;
      while (!(gnt0 || gnt1) && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        check("gnt_timeout", 32'd1, 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        break;
      end
      check("gnt_id", 32'(gnt1), 32'(w));
      check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      a = w ? addr1 : addr0;
      l = w ? len1 : len0;
      for (int i = 0; i <= int'(l); i++) begin
        ai = a + 10'(i);
        exp_q.push_back({w, ai[7:0] ^ 8'hA5});
      end
      if (w) req1 = 1'b0; else req0 = 1'b0;
      for (int i = 0; i <= int'(l); i++) begin
        check("issue_addr", 32'(rom_address), 32'(10'(a + 10'(i))));
        check("issue_busy", 32'(busy), 32'd1);
        if (i > 0) check("gnt_pulse", 32'(gnt0 | gnt1), 32'd0);
        @(negedge clk);
      end
      check("drain_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // contention twice: winner order follows the round-robin pointer
    do_req(1'b1, 10'd100, 4'd1, 1'b1, 10'd200, 4'd2);
    do_req(1'b1, 10'd300, 4'd2, 1'b1, 10'd400, 4'd1);
    // single word
    do_req(1'b1, 10'd700, 4'd0, 1'b0, 10'd0, 4'd0);
    // four-word burst from requester 1
    do_req(1'b0, 10'd0, 4'd0, 1'b1, 10'd800, 4'd3);
    // address wrap
    do_req(1'b1, 10'd1022, 4'd3, 1'b0, 10'd0, 4'd0);

    // reset during the third ISSUE cycle of a long burst
    @(negedge clk);
    req1 = 1'b1; addr1 = 10'd900; len1 = 4'd15;
    n = 0;
    while (!gnt1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(10'd900 + 10'(i)) ^ 8'hA5});
    @(negedge clk);
    @(negedge clk);
    check("mid_addr", 32'(rom_address), 32'd902);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("mid_rst_addr", 32'(rom_address), 32'd0);
    exp_q.delete();
    ptr_m = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid) n++;
    end
    check("post_rst_beats", 32'(n), 32'd0);
    do_req(1'b1, 10'd5, 4'd1, 1'b0, 10'd0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
